pll_reconfig_master: RTL and testbench

PLL_RECONFIG_MASTER -- requirements
Module: pll_reconfig_master

---
 rtl/pll_reconfig_master.sv | 166 ++++++++++++++++
 tb/tb_pll_reconfig_master.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_master.sv
// Reprograms one PLL output counter via Avalon-MM: mode, counter and start writes, then status polling and lock qualification.
// Latency: 3 writes + 1 read + LOCK_STABLE + 2 + 1 cycles minimum; every transfer stalls for as long as mgmt_waitrequest is high.
module pll_reconfig_master #(
    parameter int TIMEOUT     = 4095,
    parameter int LOCK_STABLE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_req,
    input  logic [4:0]  cfg_cnt,
    input  logic [7:0]  cfg_hi,
    input  logic [7:0]  cfg_lo,
    input  logic        cfg_odd,
    input  logic        cfg_bypass,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_read,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int ST_W = $clog2(LOCK_STABLE + 1);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
    localparam logic [ST_W-1:0] ST_LIM = ST_W'(LOCK_STABLE);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_MODE, S_WR_CNT, S_WR_START, S_RD_STAT, S_WAIT_LOCK, S_FINISH
    } state_t;

    state_t            state_q;
    logic              busy_q, done_q, error_q, read_q, write_q;
    logic [5:0]        addr_q;
    logic [31:0]       wdata_q;
    logic [4:0]        cnt_q;
    logic [7:0]        hi_q, lo_q;
    logic              odd_q, byp_q;
    logic [TO_W-1:0]   to_q, to_d;
    logic [ST_W-1:0]   stable_q, stable_d;
    logic              lock_s1_q, lock_s2_q;
    logic              to_expire, lock_ok;
    logic              unused_rd;

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign mgmt_address   = addr_q;
    assign mgmt_read      = read_q;
    assign mgmt_write     = write_q;
    assign mgmt_writedata = wdata_q;
    assign unused_rd      = ^mgmt_readdata[31:1];

    always_comb begin
        to_d      = (to_q == TO_LIM) ? to_q : to_q + 1'b1;
        to_expire = (to_d == TO_LIM);
        stable_d  = '0;
        if (lock_s2_q)
            stable_d = (stable_q == ST_LIM) ? stable_q : stable_q + 1'b1;
        lock_ok   = lock_s2_q && (stable_d == ST_LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            odd_q     <= 1'b0;
            byp_q     <= 1'b0;
            to_q      <= '0;
            stable_q  <= '0;
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            // Synchroniser held clear outside WAIT_LOCK: lock must be re-observed after the start write.
            lock_s1_q <= pll_locked && (state_q == S_WAIT_LOCK);
            lock_s2_q <= lock_s1_q;
            case (state_q)
                S_IDLE: begin
                    if (cfg_req) begin
                        cnt_q   <= cfg_cnt;
                        hi_q    <= cfg_hi;
                        lo_q    <= cfg_lo;
                        odd_q   <= cfg_odd;
                        byp_q   <= cfg_bypass;
                        busy_q  <= 1'b1;
                        write_q <= 1'b1;
                        addr_q  <= 6'd0;
                        wdata_q <= 32'h1;
                        state_q <= S_WR_MODE;
                    end
                end
                S_WR_MODE: begin
                    if (!mgmt_waitrequest) begin
                        addr_q  <= 6'd5;
                        wdata_q <= {9'b0, cnt_q, odd_q, byp_q, hi_q, lo_q};
                        state_q <= S_WR_CNT;
                    end
                end
                S_WR_CNT: begin
                    if (!mgmt_waitrequest) begin
                        addr_q  <= 6'd2;
                        wdata_q <= 32'h1;
                        state_q <= S_WR_START;
                    end
                end
                S_WR_START: begin
                    if (!mgmt_waitrequest) begin
                        write_q  <= 1'b0;
                        wdata_q  <= '0;
                        read_q   <= 1'b1;
                        addr_q   <= 6'd1;
                        to_q     <= '0;
                        stable_q <= '0;
                        state_q  <= S_RD_STAT;
                    end
                end
                S_RD_STAT: begin
                    to_q <= to_d;
                    if (to_expire) begin
                        read_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        addr_q  <= '0;
                        state_q <= S_FINISH;
                    end else if (read_q) begin
                        if (!mgmt_waitrequest) begin
                            read_q <= 1'b0;
                            if (mgmt_readdata[0]) begin
                                addr_q  <= '0;
                                state_q <= S_WAIT_LOCK;
                            end
                        end
                    end else begin
                        read_q <= 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    to_q     <= to_d;
                    stable_q <= stable_d;
                    if (to_expire || lock_ok) begin
                        busy_q  <= 1'b0;
                        error_q <= to_expire;
                        done_q  <= !to_expire;
                        state_q <= S_FINISH;
                    end
                end
                S_FINISH: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pll_reconfig_master.sv
// Scoreboard bench: stimulus pushes expected bus/done/error events; a negedge monitor pops and compares them.
module tb_pll_reconfig_master;
    localparam int LS = 16;
    localparam int TO = 64;
    localparam int EV_WR = 0, EV_RD = 1, EV_DONE = 2, EV_ERR = 3;

    typedef struct {
        int          kind;
        logic [5:0]  addr;
        logic [31:0] data;
        int          hold;
        int          lat;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_req = 1'b0;
    logic [4:0]  cfg_cnt = '0;
    logic [7:0]  cfg_hi = '0, cfg_lo = '0;
    logic        cfg_odd = 1'b0, cfg_bypass = 1'b0;
    logic        busy, done, error, mgmt_read, mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata = '0;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b1;

    pll_reconfig_master #(.TIMEOUT(TO), .LOCK_STABLE(LS)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_req(cfg_req), .cfg_cnt(cfg_cnt),
        .cfg_hi(cfg_hi), .cfg_lo(cfg_lo), .cfg_odd(cfg_odd), .cfg_bypass(cfg_bypass),
        .busy(busy), .done(done), .error(error), .mgmt_address(mgmt_address),
        .mgmt_read(mgmt_read), .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
        .mgmt_readdata(mgmt_readdata), .mgmt_waitrequest(mgmt_waitrequest),
        .pll_locked(pll_locked)
    );

    always #5 clk = ~clk;

    int  n_checks = 0, n_pass = 0;
    int  cyc = 0, req_cyc = 0;
    ev_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input int kind, input logic [5:0] addr, input logic [31:0] data,
                        input int hold, input int lat);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.hold = hold; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [5:0] addr, input logic [31:0] data,
                           input int hold);
        ev_t e;
        int  lat;
        lat = cyc - req_cyc + 1;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind=%0d addr=%0h data=%0h hold=%0d lat=%0d, none expected",
                     kind, addr, data, hold, lat);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.addr == addr && e.data == data && e.hold == hold && e.lat == lat)
                n_pass++;
            else
                $display("FAIL event: got kind=%0d addr=%0h data=%0h hold=%0d lat=%0d, expected kind=%0d addr=%0h data=%0h hold=%0d lat=%0d",
                         kind, addr, data, hold, lat, e.kind, e.addr, e.data, e.hold, e.lat);
        end
    endtask

    // Slave model: stalls each write for wr_stall cycles, answers status reads.
    int wr_stall = 0, zero_reads = 0, rd_count = 0, stall_left = 0;
    bit never_ok = 1'b0, in_xfer = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!mgmt_write) in_xfer = 1'b0;
        if (mgmt_write) begin
            if (!in_xfer) begin
                in_xfer    = 1'b1;
                stall_left = wr_stall;
            end
            if (stall_left > 0) begin
                mgmt_waitrequest = 1'b1;
                stall_left--;
            end else begin
                mgmt_waitrequest = 1'b0;
                in_xfer = 1'b0;
            end
        end else begin
            mgmt_waitrequest = 1'b0;
            mgmt_readdata = (mgmt_read && !never_ok && rd_count >= zero_reads) ? 32'h1 : 32'hFFFF_FFFE;
            if (mgmt_read) rd_count++;
        end
    end

    int          hold = 0;
    logic [5:0]  h_addr;
    logic [31:0] h_data;
    bit          unstable = 1'b0, both_seen = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mgmt_read && mgmt_write) both_seen = 1'b1;
            if (mgmt_write) begin
                if (hold == 0) begin
                    h_addr = mgmt_address;
                    h_data = mgmt_writedata;
                end else if (mgmt_address != h_addr || mgmt_writedata != h_data) begin
                    unstable = 1'b1;
                end
                hold++;
                if (!mgmt_waitrequest) begin
                    observe(EV_WR, mgmt_address, mgmt_writedata, hold);
                    hold = 0;
                end
            end else begin
                hold = 0;
            end
            if (mgmt_read && !mgmt_waitrequest) observe(EV_RD, mgmt_address, 32'd0, 1);
            if (done) observe(EV_DONE, 6'd0, 32'd0, 0);
            if (error) observe(EV_ERR, 6'd0, 32'd0, 0);
            if (done || error) begin
                chk("busy_at_end", {63'd0, busy}, 64'd0);
                chk("done_error_exclusive", {63'd0, done & error}, 64'd0);
            end
        end else begin
            hold = 0;
        end
    end

    task automatic do_req(input logic [4:0] cnt, input logic [7:0] hi, input logic [7:0] lo,
                          input logic odd, input logic byp);
        @(posedge clk); #1;
        cfg_cnt = cnt; cfg_hi = hi; cfg_lo = lo; cfg_odd = odd; cfg_bypass = byp;
        cfg_req = 1'b1;
        @(posedge clk); #1;
        req_cyc = cyc;
        cfg_req = 1'b0;
        cfg_cnt = 5'h0A; cfg_hi = 8'h5A; cfg_lo = 8'hC3; cfg_odd = ~odd; cfg_bypass = ~byp;
        chk("busy_after_req", {63'd0, busy}, 64'd1);
    endtask

    task automatic push_writes(input logic [31:0] word, input int stall);
        int h;
        h = stall + 1;
        push(EV_WR, 6'd0, 32'h1, h, h);
        push(EV_WR, 6'd5, word, h, 2 * h);
        push(EV_WR, 6'd2, 32'h1, h, 3 * h);
    endtask

    task automatic setup(input int stall, input int zr, input bit never);
        wr_stall = stall; zero_reads = zr; never_ok = never; rd_count = 0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL %s_timeout: %0d events pending after %0d cycles, required 0", name, exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (8) @(posedge clk);
        chk({name, "_strobe_stable"}, {63'd0, unstable}, 64'd0);
        unstable = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},  {63'd0, busy}, 64'd0);
        chk({tag, "_done"},  {63'd0, done}, 64'd0);
        chk({tag, "_error"}, {63'd0, error}, 64'd0);
        chk({tag, "_read"},  {63'd0, mgmt_read}, 64'd0);
        chk({tag, "_write"}, {63'd0, mgmt_write}, 64'd0);
        chk({tag, "_addr"},  {58'd0, mgmt_address}, 64'd0);
        chk({tag, "_wdata"}, {32'd0, mgmt_writedata}, 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 chk_idle_outputs("reset");
        rst_n = 1'b1;

        // Nominal, plus a second request while busy that must be ignored.
        setup(0, 0, 1'b0);
        push_writes(32'h0004_0707, 0);
        push(EV_RD, 6'd1, 32'd0, 1, 4);
        push(EV_DONE, 6'd0, 32'd0, 0, LS + 7);
        do_req(5'd1, 8'd7, 8'd7, 1'b0, 1'b0);
        @(posedge clk); #1;
        cfg_cnt = 5'd3; cfg_hi = 8'd2; cfg_lo = 8'd9; cfg_req = 1'b1;
        @(posedge clk); #1 cfg_req = 1'b0;
        wait_drain("nominal", 100);

        // Out-of-range counter index written unchanged; request on the FINISH cycle ignored.
        setup(0, 0, 1'b0);
        push_writes(32'h007F_A53C, 0);
        push(EV_RD, 6'd1, 32'd0, 1, 4);
        push(EV_DONE, 6'd0, 32'd0, 0, LS + 7);
        do_req(5'd31, 8'hA5, 8'h3C, 1'b1, 1'b1);
        repeat (LS + 6) @(posedge clk);
        #1 cfg_req = 1'b1;
        @(posedge clk); #1 cfg_req = 1'b0;
        wait_drain("finish_req", 100);
        chk("finish_req_idle", {63'd0, busy}, 64'd0);

        // Each write stalled 5 cycles, so every strobe is held 6.
        setup(5, 0, 1'b0);
        push_writes(32'h0004_0707, 5);
        push(EV_RD, 6'd1, 32'd0, 1, 19);
        push(EV_DONE, 6'd0, 32'd0, 0, LS + 22);
        do_req(5'd1, 8'd7, 8'd7, 1'b0, 1'b0);
        wait_drain("stall", 150);

        // Three not-ready status reads, each followed by one idle cycle.
        setup(0, 3, 1'b0);
        push_writes(32'h0004_0707, 0);
        for (int k = 0; k < 4; k++) push(EV_RD, 6'd1, 32'd0, 1, 4 + 2 * k);
        push(EV_DONE, 6'd0, 32'd0, 0, LS + 13);
        do_req(5'd1, 8'd7, 8'd7, 1'b0, 1'b0);
        wait_drain("polling", 150);

        // Lock drops for one cycle while the stable count is 10: count restarts, done 13 cycles late.
        setup(0, 0, 1'b0);
        push_writes(32'h0004_0707, 0);
        push(EV_RD, 6'd1, 32'd0, 1, 4);
        push(EV_DONE, 6'd0, 32'd0, 0, 36);
        do_req(5'd1, 8'd7, 8'd7, 1'b0, 1'b0);
        repeat (16) @(posedge clk);
        #1 pll_locked = 1'b0;
        @(posedge clk); #1 pll_locked = 1'b1;
        wait_drain("lock_glitch", 150);

        // Status never ready: reads every other cycle until the timeout fires.
        setup(0, 0, 1'b1);
        push_writes(32'h0004_0707, 0);
        for (int k = 4; k <= 66; k += 2) push(EV_RD, 6'd1, 32'd0, 1, k);
        push(EV_ERR, 6'd0, 32'd0, 0, 3 + TO + 1);
        do_req(5'd1, 8'd7, 8'd7, 1'b0, 1'b0);
        wait_drain("timeout", 200);

        // Reset while the counter write is stalled.
        setup(20, 0, 1'b0);
        push(EV_WR, 6'd0, 32'h1, 21, 21);
        do_req(5'd1, 8'd7, 8'd7, 1'b0, 1'b0);
        repeat (23) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_idle_outputs("mid_reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("post_reset_idle", {63'd0, busy}, 64'd0);
        wait_drain("mid_reset", 50);

        chk("read_write_exclusive", {63'd0, both_seen}, 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
